load_store_unit: RTL

Initiator side of the byte-addressable data-memory interface. It takes one load or store request per transaction from the datapath, checks alignment, and drives the RAM handshake (`ram_enable`, `ram_readWrite`, `ram_MAS`, `ram_A`, `ram_done`). It returns right-justified, zero- or sign-extended load data. It sits between the CPU execute stage and the 512-byte data RAM, and stalls the datapath through `busy`.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_extend.sv | 20 ++
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] MAS_BYTE     = 2'b00;
  localparam logic [1:0] MAS_HALF     = 2'b01;
  localparam logic [1:0] MAS_WORD     = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ALIGN   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_SIZE    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_extend.sv
// Right-justified load data extension: byte/half zero- or sign-extended, word passed through.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size)
      MAS_BYTE: data_out = {{24{sign & data_in[7]}}, data_in[7:0]};
      MAS_HALF: data_out = {{16{sign & data_in[15]}}, data_in[15:0]};
      default:  data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: alignment check, RAM enable/done handshake, load extension.
// Optional ram_done watchdog is compiled in when LSU_TIMEOUT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        load,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        busy,
  output logic        ram_enable,
  output logic        ram_readWrite,
  output logic [8:0]  ram_address,
  output logic [1:0]  ram_A,
  output logic [1:0]  ram_MAS,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut,
  input  logic        ram_done
);

  lsu_state_e  state_q, state_d;
  logic        load_q, load_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        ram_enable_q, ram_enable_d;
  logic        ram_rw_q, ram_rw_d;
  logic [8:0]  ram_address_q, ram_address_d;
  logic [1:0]  ram_a_q, ram_a_d;
  logic [1:0]  ram_mas_q, ram_mas_d;
  logic [31:0] ram_data_in_q, ram_data_in_d;
  logic [31:0] ext_data;

  lsu_extend u_extend (
    .data_in  (ram_dataOut),
    .size     (size_q),
    .sign     (sign_q),
    .data_out (ext_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_LOW/WAIT_HIGH.
  assign timeout_hit = ((state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH)) &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if ((state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0) || (fault_code_q == FLT_TIMEOUT);
`endif

  always_comb begin
    state_d       = state_q;
    load_d        = load_q;
    size_d        = size_q;
    sign_d        = sign_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    ram_enable_d  = ram_enable_q;
    ram_rw_d      = ram_rw_q;
    ram_address_d = ram_address_q;
    ram_a_d       = ram_a_q;
    ram_mas_d     = ram_mas_q;
    ram_data_in_d = ram_data_in_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          load_d       = load;
          size_d       = size;
          sign_d       = sign;
          addr_d       = addr;
          wdata_d      = wdata;
          fault_d      = 1'b0;
          fault_code_d = FLT_NONE;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if (size_q == SIZE_ILLEGAL) begin
          fault_d      = 1'b1;
          fault_code_d = FLT_SIZE;
          state_d      = S_RESP;
        end else if (((size_q == MAS_HALF) && addr_q[0]) ||
                     ((size_q == MAS_WORD) && (addr_q[1:0] != 2'b00))) begin
          fault_d      = 1'b1;
          fault_code_d = FLT_ALIGN;
          state_d      = S_RESP;
        end else begin
          // RAM-side outputs are registered here so they are valid throughout ISSUE.
          ram_enable_d  = 1'b1;
          ram_rw_d      = load_q;
          ram_address_d = {addr_q[8:2], 2'b00};
          ram_a_d       = addr_q[1:0];
          ram_mas_d     = size_q;
          ram_data_in_d = wdata_q;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!ram_done) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (ram_done) begin
          if (load_q) rdata_d = ext_data;
          ram_enable_d = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    // A completion arriving on the last allowed cycle still wins over the timeout.
    if (timeout_hit && !((state_q == S_WAIT_HIGH) && ram_done)) begin
      ram_enable_d = 1'b0;
      fault_d      = 1'b1;
      fault_code_d = FLT_TIMEOUT;
      state_d      = S_RESP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      load_q        <= 1'b0;
      size_q        <= MAS_BYTE;
      sign_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= FLT_NONE;
      ram_enable_q  <= 1'b0;
      ram_rw_q      <= 1'b1;
      ram_address_q <= '0;
      ram_a_q       <= '0;
      ram_mas_q     <= MAS_BYTE;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      ram_enable_q  <= ram_enable_d;
      ram_rw_q      <= ram_rw_d;
      ram_address_q <= ram_address_d;
      ram_a_q       <= ram_a_d;
      ram_mas_q     <= ram_mas_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  assign ack           = (state_q == S_RESP);
  assign fault         = ack & fault_q;
  assign fault_code    = fault_code_q;
  assign busy          = (state_q != S_IDLE);
  assign rdata         = rdata_q;
  assign ram_enable    = ram_enable_q;
  assign ram_readWrite = ram_rw_q;
  assign ram_address   = ram_address_q;
  assign ram_A         = ram_a_q;
  assign ram_MAS       = ram_mas_q;
  assign ram_dataIn    = ram_data_in_q;

endmodule
